// File: rtl/fifo_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_byte_serializer
// Description : Pops 32-bit words from a FIFO read port and streams them out
//               as OUT_W-bit chunks, MSB chunk first, over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_byte_serializer #(
  parameter int WORD_W = 32,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int NCHUNK = WORD_W / OUT_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_LOAD = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;

  // The visible chunk is always the top slice of the shift register, so the
  // output stays stable for as long as the register is not shifted.
  assign out_data = shreg[WORD_W-1 -: OUT_W];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      fifo_rd    <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
      shreg      <= '0;
      idx        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
            state   <= S_RD;
          end
        end
        S_RD: begin
          fifo_rd <= 1'b0;
          state   <= S_LOAD;
        end
        // FIFO data_out was refreshed at the RD edge, so it is valid here.
        S_LOAD: begin
          shreg     <= fifo_data;
          out_valid <= 1'b1;
          idx       <= '0;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_valid && out_ready) begin
            if (idx == LAST_IDX) begin
              out_valid  <= 1'b0;
              words_sent <= words_sent + CNT_W'(1);
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              shreg <= shreg << OUT_W;
            end
          end
        end
        default: begin
          fifo_rd   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_byte_serializer
// Description : Directed self-checking bench with a small FIFO read-port model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_byte_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_rd;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [15:0] words_sent;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fifo_byte_serializer #(.WORD_W(32), .OUT_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .words_sent (words_sent)
  );

  // FIFO read-port model: data_out updates at the edge that samples rd=1.
  logic [31:0] fmem [0:15];
  logic [3:0]  wr_ptr = 4'd0;
  logic [3:0]  rd_ptr = 4'd0;
  logic [31:0] fq_data = 32'h0;
  logic        junk = 1'b0;
  logic        junk_empty = 1'b0;
  logic [31:0] junk_data = 32'h0;

  assign fifo_empty = junk ? junk_empty : (wr_ptr == rd_ptr);
  assign fifo_data  = junk ? junk_data  : fq_data;

  always @(posedge clk) begin
    if (fifo_rd && (wr_ptr != rd_ptr)) begin
      fq_data <= fmem[rd_ptr];
      rd_ptr  <= rd_ptr + 4'd1;
    end
  end

  logic prev_rd = 1'b0;
  logic rd_b2b  = 1'b0;
  always @(posedge clk) begin
    if (fifo_rd && prev_rd) rd_b2b <= 1'b1;
    prev_rd <= fifo_rd;
  end

  task automatic push(input logic [31:0] w);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    junk = 1'b1;
    junk_empty = 1'b0;
    junk_data = 32'hDEADBEEF;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fifo_rd !== 1'b0) begin fails++; $display("FAIL reset_fifo_rd: got %b exp 0", fifo_rd); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h exp 00", out_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (words_sent !== 16'd0) begin fails++; $display("FAIL reset_words_sent: got %0d exp 0", words_sent); end
    junk = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word;
    logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] got [4];
    int at [4];
    int k = 0, rd_cnt = 0, first_rd = 0;
    push(32'hA1B2C3D4);
    out_ready = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (fifo_rd) begin rd_cnt++; if (first_rd == 0) first_rd = n; end
      if (out_valid && out_ready && k < 4) begin got[k] = out_data; at[k] = n; k++; end
      if (k == 4 && !busy) break;
    end
    checks++; if (k !== 4) begin fails++; $display("FAIL single_chunk_count: got %0d exp 4", k); end
    checks++; if (rd_cnt !== 1) begin fails++; $display("FAIL single_rd_pulses: got %0d exp 1", rd_cnt); end
    checks++; if (first_rd !== 1) begin fails++; $display("FAIL single_rd_latency: got %0d exp 1", first_rd); end
    for (int i = 0; i < k; i++) begin
      checks++; if (got[i] !== exp[i]) begin fails++; $display("FAIL single_chunk%0d: got %h exp %h", i, got[i], exp[i]); end
      checks++; if (at[i] !== 3 + i) begin fails++; $display("FAIL single_chunk%0d_cycle: got %0d exp %0d", i, at[i], 3 + i); end
    end
    checks++; if (words_sent !== 16'd1) begin fails++; $display("FAIL single_words_sent: got %0d exp 1", words_sent); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b exp 0", busy); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] got [4];
    int at [4];
    int k = 0, stall = 0;
    push(32'hA1B2C3D4);
    out_ready = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (stall > 0 && stall < 3) begin
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_hold: got %b exp 1", out_valid); end
        checks++; if (out_data !== 8'hB2) begin fails++; $display("FAIL bp_data_hold: got %h exp b2", out_data); end
        out_ready = 1'b0;
        stall++;
      end else if (stall == 0 && k == 1 && out_valid) begin
        checks++; if (out_data !== 8'hB2) begin fails++; $display("FAIL bp_first_b2: got %h exp b2", out_data); end
        out_ready = 1'b0;
        stall = 1;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && k < 4) begin got[k] = out_data; at[k] = n; k++; end
      if (k == 4 && !busy) break;
    end
    checks++; if (k !== 4) begin fails++; $display("FAIL bp_chunk_count: got %0d exp 4", k); end
    for (int i = 0; i < k; i++) begin
      checks++; if (got[i] !== exp[i]) begin fails++; $display("FAIL bp_chunk%0d: got %h exp %h", i, got[i], exp[i]); end
    end
    checks++; if (k == 4 && at[3] !== 9) begin fails++; $display("FAIL bp_last_cycle: got %0d exp 9", at[3]); end
    checks++; if (words_sent !== 16'd2) begin fails++; $display("FAIL bp_words_sent: got %0d exp 2", words_sent); end
  endtask

  task automatic test_empty;
    int rd_seen = 0, busy_seen = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fifo_rd) rd_seen++;
      if (busy) busy_seen++;
    end
    checks++; if (rd_seen !== 0) begin fails++; $display("FAIL empty_rd: got %0d pulses exp 0", rd_seen); end
    checks++; if (busy_seen !== 0) begin fails++; $display("FAIL empty_busy: got %0d busy cycles exp 0", busy_seen); end
    checks++; if (words_sent !== 16'd2) begin fails++; $display("FAIL empty_words_sent: got %0d exp 2", words_sent); end
  endtask

  task automatic test_burst;
    logic [7:0] got [32];
    int k = 0, rd_cnt = 0, last_n = 0, idle_n = 0, bad = 0;
    for (int i = 0; i < 8; i++) push(32'h01010101 * i);
    out_ready = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (fifo_rd) rd_cnt++;
      if (out_valid && out_ready && k < 32) begin got[k] = out_data; last_n = n; k++; end
      if (k == 32 && !busy) begin idle_n = n; break; end
    end
    for (int j = 0; j < k; j++) begin
      if (got[j] !== 8'(j / 4)) begin
        if (bad == 0) $display("FAIL burst_chunk%0d: got %h exp %h", j, got[j], 8'(j / 4));
        bad++;
      end
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL burst_chunk_errors: got %0d bad chunks exp 0", bad); end
    checks++; if (k !== 32) begin fails++; $display("FAIL burst_chunk_count: got %0d exp 32", k); end
    checks++; if (rd_cnt !== 8) begin fails++; $display("FAIL burst_rd_pulses: got %0d exp 8", rd_cnt); end
    checks++; if (last_n !== 55) begin fails++; $display("FAIL burst_last_chunk_cycle: got %0d exp 55", last_n); end
    checks++; if (idle_n !== 56) begin fails++; $display("FAIL burst_total_cycles: got %0d exp 56", idle_n); end
    checks++; if (words_sent !== 16'd10) begin fails++; $display("FAIL burst_words_sent: got %0d exp 10", words_sent); end
    checks++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL burst_fifo_empty: got %b exp 1", fifo_empty); end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] exp [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] got [4];
    int k = 0, rd_cnt = 0;
    push(32'h11223344);
    push(32'h55667788);
    out_ready = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (out_valid && out_ready) k++;
      if (k == 3 && out_data == 8'h33) break;
    end
    @(negedge clk);
    checks++; if (out_data !== 8'h44 || out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_reset: got valid=%b data=%h exp valid=1 data=44", out_valid, out_data); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b exp 0", out_valid); end
    checks++; if (words_sent !== 16'd0) begin fails++; $display("FAIL mid_words_sent: got %0d exp 0", words_sent); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b exp 0", busy); end
    checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL mid_out_data: got %h exp 00", out_data); end
    reset = 1'b1;
    k = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (fifo_rd) rd_cnt++;
      if (out_valid && out_ready && k < 4) begin got[k] = out_data; k++; end
      if (k == 4 && !busy) break;
    end
    checks++; if (k !== 4) begin fails++; $display("FAIL mid_next_count: got %0d exp 4", k); end
    for (int i = 0; i < k; i++) begin
      checks++; if (got[i] !== exp[i]) begin fails++; $display("FAIL mid_next_chunk%0d: got %h exp %h", i, got[i], exp[i]); end
    end
    checks++; if (rd_cnt !== 1) begin fails++; $display("FAIL mid_next_rd: got %0d exp 1", rd_cnt); end
    checks++; if (words_sent !== 16'd1) begin fails++; $display("FAIL mid_next_words_sent: got %0d exp 1", words_sent); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_empty();
    test_burst();
    test_reset_mid_word();
    checks++; if (rd_b2b !== 1'b0) begin fails++; $display("FAIL rd_back_to_back: got %b exp 0", rd_b2b); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
